// File: rtl/wave_bar_renderer.sv
// Scrolling bar-graph renderer: captures decimated, peak-held mic samples into a
// circular column history and returns the RGB565 colour of the requested pixel.
module wave_bar_renderer #(
    parameter int unsigned DECIM    = 4,
    parameter int unsigned NUM_COLS = 96,
    parameter int unsigned NUM_ROWS = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        freeze,
    input  logic        frame_begin,
    input  logic [7:0]  pos_x,
    input  logic [6:0]  pos_y,
    output logic [15:0] pixel_data,
    output logic        col_written
);

    localparam int unsigned COL_W = $clog2(NUM_COLS);
    localparam int unsigned WIN_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned H_W   = 6;
    localparam int unsigned SUM_W = 9;

    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] GREEN  = 16'h07E0;

    logic [H_W-1:0]   heights [NUM_COLS];
    logic [COL_W-1:0] wr_ptr;
    logic [COL_W-1:0] base_ptr;
    logic [WIN_W-1:0] win_cnt;
    logic [11:0]      peak;

    logic             take_c;
    logic             commit_c;
    logic [11:0]      max_c;

    // Capture decision for the current cycle
    always_comb begin
        take_c   = sample_valid & ~freeze;
        max_c    = (sample > peak) ? sample : peak;
        commit_c = take_c && (win_cnt == WIN_W'(DECIM - 1));
    end

    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] wrap_c;
    logic             in_range_c;
    logic [COL_W-1:0] col_c;
    logic [H_W-1:0]   h_c;
    logic [6:0]       rise_c;
    logic [15:0]      colour_c;

    // Column lookup by compare-and-subtract, then zone colouring by row
    always_comb begin
        sum_c      = SUM_W'(base_ptr) + SUM_W'(pos_x);
        wrap_c     = (sum_c >= SUM_W'(NUM_COLS)) ? (sum_c - SUM_W'(NUM_COLS)) : sum_c;
        in_range_c = (pos_x < 8'(NUM_COLS)) && (pos_y < 7'(NUM_ROWS));
        col_c      = in_range_c ? COL_W'(wrap_c) : '0;
        h_c        = heights[col_c];
        rise_c     = 7'(NUM_ROWS - 1) - pos_y;
        colour_c   = 16'h0000;
        if (in_range_c && (rise_c < 7'(h_c))) begin
            if (pos_y <= 7'd20) begin
                colour_c = RED;
            end else if (pos_y <= 7'd41) begin
                colour_c = YELLOW;
            end else begin
                colour_c = GREEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_COLS); i++) begin
                heights[i] <= '0;
            end
            wr_ptr      <= '0;
            base_ptr    <= '0;
            win_cnt     <= '0;
            peak        <= '0;
            pixel_data  <= 16'h0000;
            col_written <= 1'b0;
        end else begin
            pixel_data  <= colour_c;
            col_written <= commit_c;
            // base_ptr takes the pre-commit wr_ptr when both happen together
            if (frame_begin && !freeze) begin
                base_ptr <= wr_ptr;
            end
            if (commit_c) begin
                heights[wr_ptr] <= max_c[11:6];
                wr_ptr          <= (wr_ptr == COL_W'(NUM_COLS - 1)) ? '0 : (wr_ptr + COL_W'(1));
                peak            <= '0;
                win_cnt         <= '0;
            end else if (take_c) begin
                peak    <= max_c;
                win_cnt <= win_cnt + WIN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wave_bar_renderer.sv
// Bench for wave_bar_renderer: directed scenarios plus random traffic, all checked
// every cycle against a column-history model held in the bench.
module tb_wave_bar_renderer;

    localparam int DECIM = 4;
    localparam int NCOLS = 96;
    localparam int NROWS = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = '0;
    logic        freeze = 1'b0;
    logic        frame_begin = 1'b0;
    logic [7:0]  pos_x = '0;
    logic [6:0]  pos_y = '0;
    logic [15:0] pixel_data;
    logic        col_written;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: column heights, pointers, and the samples accepted in the open window
    int m_h [NCOLS];
    int m_wr   = 0;
    int m_base = 0;
    int win_q [$];

    wave_bar_renderer #(.DECIM(DECIM), .NUM_COLS(NCOLS), .NUM_ROWS(NROWS)) dut (
        .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .sample(sample),
        .freeze(freeze), .frame_begin(frame_begin), .pos_x(pos_x), .pos_y(pos_y),
        .pixel_data(pixel_data), .col_written(col_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] exp_pixel(input int x, input int y);
        int h;
        if (x >= NCOLS || y >= NROWS) return 16'h0000;
        h = m_h[(m_base + x) % NCOLS];
        if ((NROWS - 1 - y) >= h) return 16'h0000;
        if (y <= 20) return 16'hF800;
        if (y <= 41) return 16'hFFE0;
        return 16'h07E0;
    endfunction

    // One clock: predict from pre-edge model state, advance the model, compare outputs
    task automatic cycle();
        logic [15:0] ep;
        logic        ecw;
        int          nb;
        int          mx;
        ep  = rstn ? exp_pixel(int'(pos_x), int'(pos_y)) : 16'h0000;
        ecw = 1'b0;
        if (!rstn) begin
            for (int i = 0; i < NCOLS; i++) m_h[i] = 0;
            m_wr = 0;
            m_base = 0;
            win_q.delete();
        end else begin
            nb = (frame_begin && !freeze) ? m_wr : m_base;
            if (sample_valid && !freeze) begin
                win_q.push_back(int'(sample));
                if (win_q.size() == DECIM) begin
                    mx = 0;
                    foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
                    m_h[m_wr] = mx / 64;
                    m_wr = (m_wr + 1) % NCOLS;
                    win_q.delete();
                    ecw = 1'b1;
                end
            end
            m_base = nb;
        end
        @(posedge clk);
        #1;
        check("pixel", pixel_data, ep);
        check("col_written", 16'(col_written), 16'(ecw));
    endtask

    task automatic push(input logic [11:0] s, input logic fb);
        sample_valid = 1'b1;
        sample = s;
        frame_begin = fb;
        cycle();
        sample_valid = 1'b0;
        frame_begin = 1'b0;
    endtask

    task automatic new_frame();
        frame_begin = 1'b1;
        cycle();
        frame_begin = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [15:0] exp_v);
        pos_x = 8'(x);
        pos_y = 7'(y);
        cycle();
        check(tag, pixel_data, exp_v);
    endtask

    initial begin
        for (int i = 0; i < NCOLS; i++) m_h[i] = 0;

        // Reset, some traffic, then a reset on a would-be commit cycle
        cycle();
        cycle();
        rstn = 1'b1;
        for (int i = 0; i < 23; i++) push(12'hFFF, 1'b0);
        new_frame();
        rstn = 1'b0;
        sample_valid = 1'b1;
        sample = 12'hFFF;
        pos_x = 8'd0;
        pos_y = 7'd63;
        cycle();
        sample_valid = 1'b0;
        check("rst_pixel", pixel_data, 16'h0000);
        check("rst_col_written", 16'(col_written), 16'h0000);
        rstn = 1'b1;
        new_frame();
        for (int x = 0; x < NCOLS; x++)
            for (int y = 0; y < NROWS; y++) begin
                pos_x = 8'(x);
                pos_y = 7'(y);
                cycle();
            end
        probe("rst_scan_corner", 95, 63, 16'h0000);

        // Single window 100,4095,200,50 -> height 63 at column 0
        push(12'd100, 1'b0);
        push(12'd4095, 1'b0);
        push(12'd200, 1'b0);
        push(12'd50, 1'b0);
        check("single_commit", 16'(col_written), 16'h0001);
        new_frame();
        probe("single_y63", 95, 63, 16'h07E0);
        probe("single_y30", 95, 30, 16'hFFE0);
        probe("single_y1", 95, 1, 16'hF800);
        probe("single_y0", 95, 0, 16'h0000);

        // Threshold: max 64 -> height 1; max 63 -> height 0
        push(12'd64, 1'b0); push(12'd0, 1'b0); push(12'd10, 1'b0); push(12'd5, 1'b0);
        new_frame();
        probe("h1_y63", 95, 63, 16'h07E0);
        probe("h1_y62", 95, 62, 16'h0000);
        push(12'd63, 1'b0); push(12'd1, 1'b0); push(12'd2, 1'b0); push(12'd3, 1'b0);
        new_frame();
        probe("h0_y63", 95, 63, 16'h0000);
        probe("h1_prev_col", 94, 63, 16'h07E0);

        // Wrap: 97 commits of height k mod 64
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        for (int k = 1; k <= 97; k++) begin
            push(12'((k % 64) * 64), 1'b0);
            push(12'd0, 1'b0);
            push(12'd0, 1'b0);
            push(12'd0, 1'b0);
        end
        new_frame();
        probe("wrap_x0_y62", 0, 62, 16'h07E0);
        probe("wrap_x0_y61", 0, 61, 16'h0000);
        probe("wrap_x95_y31", 95, 31, 16'hFFE0);
        probe("wrap_x95_y30", 95, 30, 16'h0000);

        // Freeze mid-window; frame_begin while frozen must not move base_ptr
        for (int i = 0; i < DECIM; i++) push(12'd0, 1'b0);
        push(12'd500, 1'b0);
        push(12'd3000, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) push(12'hFFF, (i == 4) ? 1'b1 : 1'b0);
        probe("frz_base_hold", 95, 31, 16'hFFE0);
        freeze = 1'b0;
        push(12'd100, 1'b0);
        push(12'd200, 1'b0);
        check("frz_release_commit", 16'(col_written), 16'h0001);
        new_frame();
        probe("frz_peak_y18", 95, 18, 16'hF800);
        probe("frz_peak_y17", 95, 17, 16'h0000);

        // Out-of-range coordinates
        probe("edge_x96", 96, 63, 16'h0000);
        probe("edge_y64", 0, 64, 16'h0000);
        probe("edge_x255", 255, 0, 16'h0000);
        probe("edge_y127", 95, 127, 16'h0000);

        // frame_begin coincident with a commit takes the pre-commit wr_ptr
        push(12'hFFF, 1'b0);
        push(12'd0, 1'b0);
        push(12'd0, 1'b0);
        push(12'd0, 1'b1);
        check("coinc_commit", 16'(col_written), 16'h0001);
        probe("coinc_x0_y1", 0, 1, 16'hF800);
        probe("coinc_x95_y63", 95, 63, 16'h07E0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rstn         = ($urandom_range(0, 499) != 0);
            sample_valid = $urandom_range(0, 2) != 0;
            sample       = 12'($urandom);
            freeze       = ($urandom_range(0, 9) == 0);
            frame_begin  = ($urandom_range(0, 39) == 0);
            pos_x        = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, NCOLS - 1));
            pos_y        = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, NROWS - 1));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
